// File: rtl/spi_reg_pkg.sv
// ============================================================================
// Module : spi_reg_pkg
// Brief  : Shared constants and FSM state type for the SPI register slave.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package spi_reg_pkg;

    localparam int         FRAME_BITS       = 16;
    localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
    localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
    localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
    localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
    localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

    // Bit counter sticks one past a full frame so long frames stay distinguishable.
    localparam logic [4:0] CNT_FULL = 5'd16;
    localparam logic [4:0] CNT_SAT  = 5'd17;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } spi_state_t;

endpackage

`default_nettype wire

// File: rtl/spi_sync.sv
// ============================================================================
// Module : spi_sync
// Brief  : Multi-flop synchronizer for one asynchronous pin plus edge detect.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    // Resetting to the pin's idle level keeps reset release edge-free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{RESET_VAL}};
            r_prev <= RESET_VAL;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], async_in};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign level = r_sync[SYNC_STAGES-1];
    assign rise  = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign fall  = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

`default_nettype wire

// File: rtl/spi_reg_peripheral.sv
// ============================================================================
// Module : spi_reg_peripheral
// Brief  : SPI mode-0 write-only slave holding the PWM configuration registers.
//          Define SPI_FRAME_ERR_EN to add the frame_err_cnt output.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module spi_reg_peripheral
    import spi_reg_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int NUM_REGS    = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
`ifdef SPI_FRAME_ERR_EN
    output logic [7:0] frame_err_cnt,
`endif
    output logic [7:0] pwm_duty_cycle
);

    localparam logic [7:0] c_num_regs = 8'(NUM_REGS);

    logic w_sclk_level, w_sclk_rise, w_sclk_fall;
    logic w_copi_level, w_copi_rise, w_copi_fall;
    logic w_ncs_level,  w_ncs_rise,  w_ncs_fall;

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (sclk),
        .level    (w_sclk_level),
        .rise     (w_sclk_rise),
        .fall     (w_sclk_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (copi),
        .level    (w_copi_level),
        .rise     (w_copi_rise),
        .fall     (w_copi_fall)
    );

    spi_sync #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (ncs),
        .level    (w_ncs_level),
        .rise     (w_ncs_rise),
        .fall     (w_ncs_fall)
    );

    logic w_unused;
    assign w_unused = &{1'b0, w_sclk_level, w_sclk_fall, w_copi_rise, w_copi_fall, w_ncs_level};

    spi_state_t            r_state;
    logic [FRAME_BITS-1:0] r_shift;
    logic [4:0]            r_cnt;

    logic [6:0] w_addr;
    logic       w_frame_ok;
    logic       w_wr_ok;

    assign w_addr     = r_shift[14:8];
    assign w_frame_ok = (r_cnt == CNT_FULL) && ({1'b0, w_addr} < c_num_regs);
    assign w_wr_ok    = w_frame_ok && r_shift[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_shift         <= '0;
            r_cnt           <= '0;
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_ncs_fall) begin
                        r_shift <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // A bit arriving with the ncs rise is still captured before commit.
                    if (w_sclk_rise) begin
                        r_shift <= {r_shift[FRAME_BITS-2:0], w_copi_level};
                        if (r_cnt != CNT_SAT) begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                    if (w_ncs_rise) begin
                        r_state <= ST_COMMIT;
                    end
                end
                ST_COMMIT: begin
                    if (w_wr_ok) begin
                        case (w_addr)
                            ADDR_EN_OUT_7_0:  en_reg_out_7_0  <= r_shift[7:0];
                            ADDR_EN_OUT_15_8: en_reg_out_15_8 <= r_shift[7:0];
                            ADDR_EN_PWM_7_0:  en_reg_pwm_7_0  <= r_shift[7:0];
                            ADDR_EN_PWM_15_8: en_reg_pwm_15_8 <= r_shift[7:0];
                            ADDR_PWM_DUTY:    pwm_duty_cycle  <= r_shift[7:0];
                            default: ;
                        endcase
                    end
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef SPI_FRAME_ERR_EN
    // Reads to valid addresses are legal traffic, not errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_err_cnt <= 8'h00;
        end else if ((r_state == ST_COMMIT) && !w_frame_ok && (frame_err_cnt != 8'hFF)) begin
            frame_err_cnt <= frame_err_cnt + 8'h01;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_spi_reg_peripheral.sv
// ============================================================================
// Module : tb_spi_reg_peripheral
// Brief  : Directed and random SPI frames checked against a register model.
// Rev    : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_spi_reg_peripheral;

    localparam int SYNC_STAGES = 2;
    localparam int NUM_REGS    = 5;
    localparam int HALF_SLOW   = 50;
    localparam int MIN_GAP     = SYNC_STAGES + 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
`ifdef SPI_FRAME_ERR_EN
    logic [7:0] frame_err_cnt;
`endif

    spi_reg_peripheral #(
        .SYNC_STAGES (SYNC_STAGES),
        .NUM_REGS    (NUM_REGS)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
`ifdef SPI_FRAME_ERR_EN
        .frame_err_cnt   (frame_err_cnt),
`endif
        .pwm_duty_cycle  (pwm_duty_cycle)
    );

    always #50 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] m_regs [NUM_REGS];
    int         m_err;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed=%02h expected=%02h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, "_out_lo"}, en_reg_out_7_0,  m_regs[0]);
        chk({pfx, "_out_hi"}, en_reg_out_15_8, m_regs[1]);
        chk({pfx, "_pwm_lo"}, en_reg_pwm_7_0,  m_regs[2]);
        chk({pfx, "_pwm_hi"}, en_reg_pwm_15_8, m_regs[3]);
        chk({pfx, "_duty"},   pwm_duty_cycle,  m_regs[4]);
`ifdef SPI_FRAME_ERR_EN
        chk({pfx, "_err"},    frame_err_cnt,   8'(m_err));
`endif
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
        m_err = 0;
    endfunction

    // Only a 16-bit write to an implemented address changes a register.
    function automatic void model_frame(input logic [31:0] data, input int nbits);
        logic [15:0] word;
        int          addr;
        word = data[15:0];
        addr = int'(word[14:8]);
        if (nbits != 16 || addr >= NUM_REGS) begin
            if (m_err < 255) m_err++;
        end else if (word[15]) begin
            m_regs[addr] = word[7:0];
        end
    endfunction

    // Leaves ncs asserted after the last bit so callers control the release.
    task automatic spi_bits(input logic [31:0] data, input int nbits, input int half);
        ncs = 1'b0;
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = data[i];
            wait_clks(half);
            sclk = 1'b1;
            wait_clks(half);
            sclk = 1'b0;
        end
        wait_clks(half);
    endtask

    task automatic send(input logic [31:0] data, input int nbits, input int half, input int gap);
        spi_bits(data, nbits, half);
        ncs  = 1'b1;
        copi = 1'b0;
        wait_clks(gap);
        model_frame(data, nbits);
    endtask

    initial begin
        logic [31:0] data;
        int          kind, nbits, half, gap;

        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        model_reset();
        wait_clks(5);
        rst_n = 1'b1;

        wait_clks(100);
        check_all("reset");

        send(32'h80FF, 16, HALF_SLOW, 10);
        send(32'h8155, 16, HALF_SLOW, 10);
        send(32'h82AA, 16, HALF_SLOW, 10);
        send(32'h83F0, 16, HALF_SLOW, 10);
        spi_bits(32'h8480, 16, HALF_SLOW);
        ncs = 1'b1;
        wait_clks(SYNC_STAGES + 1);
        chk("duty_lat_before", pwm_duty_cycle, 8'h00);
        wait_clks(1);
        chk("duty_lat_after", pwm_duty_cycle, 8'h80);
        wait_clks(10);
        model_frame(32'h8480, 16);
        check_all("writes");

        send(32'h04FF, 16, HALF_SLOW, 10);
        check_all("read");
        send(32'h85CC, 16, HALF_SLOW, 10);
        check_all("bad_addr");

        send(32'h0000_4033, 15, HALF_SLOW, 10);
        check_all("short");
        send(32'h0001_0077, 17, HALF_SLOW, 10);
        check_all("long");

        spi_bits(32'h0000_0080, 8, HALF_SLOW);
        rst_n = 1'b0;
        wait_clks(5);
        ncs  = 1'b1;
        copi = 1'b0;
        wait_clks(3);
        rst_n = 1'b1;
        model_reset();
        wait_clks(10);
        check_all("abort");
        send(32'h8033, 16, HALF_SLOW, 10);
        check_all("restart");

        send(32'h8011, 16, 3, MIN_GAP);
        send(32'h8022, 16, 3, 10);
        check_all("b2b");

        for (int it = 0; it < 30; it++) begin
            kind  = int'($urandom_range(0, 9));
            data  = {16'h0000, 1'b1, 7'($urandom_range(0, NUM_REGS - 1)), 8'($urandom)};
            nbits = 16;
            if (kind == 6) begin
                data[15] = 1'b0;
            end else if (kind == 7) begin
                data[14:8] = 7'($urandom_range(NUM_REGS, 127));
            end else if (kind == 8) begin
                nbits = int'($urandom_range(1, 15));
            end else if (kind == 9) begin
                nbits = int'($urandom_range(17, 20));
                data  = data | (32'($urandom) << 16);
            end
            half = int'($urandom_range(3, 6));
            gap  = int'($urandom_range(6, 10));
            send(data, nbits, half, gap);
            check_all($sformatf("rand%0d", it));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
